bp_fe_icache_mem_responder: RTL and testbench

//  Synthesizable BedRock stream memory endpoint that sits directly downstream of the I$ engine
//  (UCE or FSM CCE) in the bp_fe_icache test harness.

---
 rtl/bp_fe_icache_mem_responder_if.sv | 40 ++++
 rtl/bp_fe_icache_mem_responder.sv | 191 +++++++++++++++++++
 tb/tb_bp_fe_icache_mem_responder.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_fe_icache_mem_responder_if.sv
// BedRock stream fwd/rev channel pair between the I$ engine and its memory endpoint.
// Header structs are carried as flat fields: msg_type, size, addr, payload.
`timescale 1ns/1ps
interface bp_fe_icache_mem_responder_if #(
  parameter int paddr_width_p   = 40,
  parameter int data_width_p    = 64,
  parameter int payload_width_p = 16
);
  logic [3:0]                 mem_fwd_msg_type;
  logic [2:0]                 mem_fwd_size;
  logic [paddr_width_p-1:0]   mem_fwd_addr;
  logic [payload_width_p-1:0] mem_fwd_payload;
  logic [data_width_p-1:0]    mem_fwd_data;
  logic                       mem_fwd_v;
  logic                       mem_fwd_ready_and;

  logic [3:0]                 mem_rev_msg_type;
  logic [2:0]                 mem_rev_size;
  logic [paddr_width_p-1:0]   mem_rev_addr;
  logic [payload_width_p-1:0] mem_rev_payload;
  logic [data_width_p-1:0]    mem_rev_data;
  logic                       mem_rev_v;
  logic                       mem_rev_ready_and;

  // request side (I$ engine / bench)
  modport master (
    output mem_fwd_msg_type, mem_fwd_size, mem_fwd_addr, mem_fwd_payload, mem_fwd_data, mem_fwd_v,
    input  mem_fwd_ready_and,
    input  mem_rev_msg_type, mem_rev_size, mem_rev_addr, mem_rev_payload, mem_rev_data, mem_rev_v,
    output mem_rev_ready_and
  );

  // memory endpoint side
  modport slave (
    input  mem_fwd_msg_type, mem_fwd_size, mem_fwd_addr, mem_fwd_payload, mem_fwd_data, mem_fwd_v,
    output mem_fwd_ready_and,
    output mem_rev_msg_type, mem_rev_size, mem_rev_addr, mem_rev_payload, mem_rev_data, mem_rev_v,
    input  mem_rev_ready_and
  );
endinterface

// File: rtl/bp_fe_icache_mem_responder.sv
// BedRock stream memory endpoint for the I$ test harness: accepts one fwd message,
// waits latency_p cycles, then returns the rev response from a local word store.
// Processor config is reduced to the three widths this block needs (beat width >= 64).
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  e_ready | idle, accepting the first fwd beat (header latched here)
//  e_wdata | accepting write data beats 2..N
//  e_wait  | latency down-counter running, fwd and rev both closed
//  e_rev   | driving rev beats (N for reads, 1 for writes)
`timescale 1ns/1ps
module bp_fe_icache_mem_responder #(
  parameter int paddr_width_p   = 40,
  parameter int l2_data_width_p = 64,
  parameter int payload_width_p = 16,
  parameter int mem_words_p     = 1024,
  parameter int latency_p       = 4
) (
  input logic                         clk_i,
  input logic                         reset_n_i,
  bp_fe_icache_mem_responder_if.slave mem_if
);

  localparam int bytes_lp  = l2_data_width_p / 8;
  localparam int byte_w_lp = $clog2(bytes_lp);
  localparam int idx_w_lp  = $clog2(mem_words_p);

  typedef enum logic [1:0] {e_ready, e_wdata, e_wait, e_rev} state_e;

  state_e                      state_r, state_n;
  logic                        en_r;
  logic [3:0]                  msg_r;
  logic [2:0]                  size_r;
  logic [paddr_width_p-1:0]    addr_r;
  logic [payload_width_p-1:0]  payload_r;
  logic [7:0]                  beat_r;
  logic [3:0]                  lat_r;
  logic                        fwd_ready, fwd_hs;

  logic [l2_data_width_p-1:0]  mem_r [mem_words_p];

  logic [paddr_width_p-1:0]    cur_addr;
  logic [2:0]                  cur_size;
  logic [3:0]                  cur_msg;
  logic [7:0]                  cur_k;
  logic [idx_w_lp-1:0]         wr_idx;
  logic [byte_w_lp-1:0]        wr_off;
  logic [l2_data_width_p-1:0]  wr_data, wr_mask;
  logic                        wr_en;

  logic [idx_w_lp-1:0]         rd_idx;
  logic [l2_data_width_p-1:0]  rd_word, rd_shift, rd_rep;
  logic [byte_w_lp-1:0]        rd_off;
  logic                        rd_sub;
  logic                        rev_active, rev_multi;

  // last beat index: N-1 where N = max(1, bytes / beat bytes)
  function automatic logic [7:0] beat_last(input logic [2:0] size);
    logic [7:0] r;
    r = '0;
    if (int'(size) > byte_w_lp) r = 8'((1 << (int'(size) - byte_w_lp)) - 1);
    return r;
  endfunction

  function automatic logic is_wr(input logic [3:0] msg);
    return (msg == 4'd1) || (msg == 4'd3);
  endfunction

  // word index of beat k: critical word first, wrapping inside the size-aligned region
  function automatic logic [idx_w_lp-1:0] beat_idx(input logic [paddr_width_p-1:0] addr,
                                                   input logic [2:0] size, input logic [7:0] k);
    logic [idx_w_lp-1:0] start, mask;
    start = addr[byte_w_lp +: idx_w_lp];
    mask  = idx_w_lp'(beat_last(size));
    return (start & ~mask) | ((start + idx_w_lp'(k)) & mask);
  endfunction

  assign fwd_hs = mem_if.mem_fwd_v & fwd_ready;

  // state register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= e_ready;
    else            state_r <= state_n;
  end

  // next state and fwd ready
  always_comb begin
    state_n   = state_r;
    fwd_ready = 1'b0;
    case (state_r)
      e_ready: begin
        fwd_ready = en_r;
        if (mem_if.mem_fwd_v && en_r)
          state_n = (is_wr(mem_if.mem_fwd_msg_type) && beat_last(mem_if.mem_fwd_size) != 8'd0)
                    ? e_wdata : e_wait;
      end
      e_wdata: begin
        fwd_ready = 1'b1;
        if (mem_if.mem_fwd_v && beat_r == beat_last(size_r)) state_n = e_wait;
      end
      e_wait: if (lat_r == 4'd0) state_n = e_rev;
      e_rev: if (mem_if.mem_rev_ready_and && (is_wr(msg_r) || beat_r == beat_last(size_r)))
               state_n = e_ready;
      default: state_n = e_ready;
    endcase
  end

  // header latch, beat counter and latency down-counter; en_r keeps fwd closed until the first edge after reset
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      en_r      <= 1'b0;
      msg_r     <= '0;
      size_r    <= '0;
      addr_r    <= '0;
      payload_r <= '0;
      beat_r    <= '0;
      lat_r     <= '0;
    end else begin
      en_r <= 1'b1;
      if (state_r == e_ready && fwd_hs) begin
        msg_r     <= mem_if.mem_fwd_msg_type;
        size_r    <= mem_if.mem_fwd_size;
        addr_r    <= mem_if.mem_fwd_addr;
        payload_r <= mem_if.mem_fwd_payload;
        beat_r    <= (state_n == e_wdata) ? 8'd1 : 8'd0;
      end else if (state_r == e_wdata && fwd_hs) begin
        beat_r <= (state_n == e_wait) ? 8'd0 : beat_r + 8'd1;
      end else if (state_r == e_rev && mem_if.mem_rev_ready_and) begin
        beat_r <= (state_n == e_ready) ? 8'd0 : beat_r + 8'd1;
      end
      if (state_r != e_wait && state_n == e_wait) lat_r <= 4'(latency_p - 1);
      else if (state_r == e_wait && lat_r != 4'd0) lat_r <= lat_r - 4'd1;
    end
  end

  // write path: first beat uses the live header, later beats the latched one
  always_comb begin
    cur_addr = (state_r == e_ready) ? mem_if.mem_fwd_addr     : addr_r;
    cur_size = (state_r == e_ready) ? mem_if.mem_fwd_size     : size_r;
    cur_msg  = (state_r == e_ready) ? mem_if.mem_fwd_msg_type : msg_r;
    cur_k    = (state_r == e_ready) ? 8'd0 : beat_r;
    wr_idx   = beat_idx(cur_addr, cur_size, cur_k);
    wr_off   = (int'(cur_size) < byte_w_lp) ? cur_addr[byte_w_lp-1:0] : '0;
    wr_data  = mem_if.mem_fwd_data << {wr_off, 3'b000};
    wr_mask  = '0;
    for (int i = 0; i < bytes_lp; i++)
      wr_mask[8*i +: 8] = (int'(cur_size) >= byte_w_lp ||
                           (i >= int'(wr_off) && i < int'(wr_off) + (1 << int'(cur_size))))
                          ? 8'hFF : 8'h00;
    wr_en    = fwd_hs && is_wr(cur_msg);
  end

  // backing store, deliberately not reset
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_r[wr_idx] <= (mem_r[wr_idx] & ~wr_mask) | (wr_data & wr_mask);
  end

  // read path: sub-beat reads replicate the requested bytes across the beat
  always_comb begin
    rd_idx   = beat_idx(addr_r, size_r, beat_r);
    rd_word  = mem_r[rd_idx];
    rd_sub   = int'(size_r) < byte_w_lp;
    rd_off   = rd_sub ? addr_r[byte_w_lp-1:0] : '0;
    rd_shift = rd_word >> {rd_off, 3'b000};
    rd_rep   = '0;
    for (int i = 0; i < bytes_lp; i++)
      rd_rep[8*i +: 8] = rd_shift[8*(i & ((1 << int'(size_r)) - 1)) +: 8];
  end

  assign rev_active = (state_r == e_rev);
  assign rev_multi  = (beat_last(size_r) != 8'd0) && !is_wr(msg_r);

  assign mem_if.mem_fwd_ready_and = fwd_ready;
  assign mem_if.mem_rev_v         = rev_active;
  assign mem_if.mem_rev_msg_type  = rev_active ? msg_r     : '0;
  assign mem_if.mem_rev_size      = rev_active ? size_r    : '0;
  assign mem_if.mem_rev_payload   = rev_active ? payload_r : '0;
  assign mem_if.mem_rev_addr      = !rev_active ? '0 :
    rev_multi ? {addr_r[paddr_width_p-1:byte_w_lp+idx_w_lp], rd_idx, {byte_w_lp{1'b0}}} : addr_r;
  assign mem_if.mem_rev_data      = (rev_active && !is_wr(msg_r)) ? (rd_sub ? rd_rep : rd_word) : '0;

`ifndef SYNTHESIS
  // anything other than rd/wr/uc_rd/uc_wr is served as a read of the same size
  always_ff @(posedge clk_i) begin
    if (state_r == e_ready && fwd_hs && mem_if.mem_fwd_msg_type > 4'd3)
      $error("bp_fe_icache_mem_responder: unsupported msg_type %0d served as read",
             mem_if.mem_fwd_msg_type);
  end
`endif

endmodule

// File: tb/tb_bp_fe_icache_mem_responder.sv
// Bench for bp_fe_icache_mem_responder: directed harness scenarios followed by
// random traffic, all checked against a byte-level reference store.
`timescale 1ns/1ps
module tb_bp_fe_icache_mem_responder;

  localparam int LAT = 4;
  localparam logic [3:0] RD = 4'd0, WR = 4'd1, UCRD = 4'd2, UCWR = 4'd3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bp_fe_icache_mem_responder_if #(.paddr_width_p(40), .data_width_p(64), .payload_width_p(16)) mem_if ();

  bp_fe_icache_mem_responder #(
    .paddr_width_p(40), .l2_data_width_p(64), .payload_width_p(16),
    .mem_words_p(1024), .latency_p(LAT)
  ) dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .mem_if(mem_if.slave)
  );

  int          checks = 0;
  int          failures = 0;
  logic [63:0] ref_mem [1024];
  logic [63:0] wbuf [16];
  logic [63:0] beat_log [16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nbeats(input int size);
    return ((1 << size) > 8) ? (1 << size) / 8 : 1;
  endfunction

  function automatic int beat_word(input logic [39:0] addr, input int size, input int k);
    int start, n;
    start = int'((addr >> 3) % 40'd1024);
    n = nbeats(size);
    return (start / n) * n + (start + k) % n;
  endfunction

  function automatic logic [39:0] exp_addr(input logic [39:0] addr, input int size, input int k);
    int n;
    n = nbeats(size);
    if (n == 1) return addr;
    return (addr / 40'(n * 8)) * 40'(n * 8) + 40'(((int'((addr >> 3) % 40'(n)) + k) % n) * 8);
  endfunction

  function automatic logic [63:0] exp_read(input logic [39:0] addr, input int size, input int k);
    int w, off, nb;
    logic [63:0] v, r;
    w = beat_word(addr, size, k);
    if (size >= 3) return ref_mem[w];
    nb  = 1 << size;
    off = int'(addr[2:0]);
    v = (ref_mem[w] >> (8 * off)) & ((64'd1 << (8 * nb)) - 64'd1);
    r = '0;
    for (int j = 0; j < 8 / nb; j++) r = r | (v << (8 * nb * j));
    return r;
  endfunction

  task automatic model_write(input logic [39:0] addr, input int size, input int k, input logic [63:0] d);
    int w, off;
    w = beat_word(addr, size, k);
    if (size >= 3) ref_mem[w] = d;
    else begin
      off = int'(addr[2:0]);
      for (int j = 0; j < (1 << size); j++) ref_mem[w][8*(off+j) +: 8] = d[8*j +: 8];
    end
  endtask

  // one full transaction; bp_mode 0: rev always ready, 1: 1,0,0 pattern, 2: random.
  // abort_after > 0 pulls reset after that many rev transfers.
  task automatic do_txn(input logic [3:0] msg, input logic [2:0] size, input logic [39:0] addr,
                        input logic [15:0] payload, input int bp_mode, input int abort_after);
    int  n, nrev, cyc, xfers, pat;
    bit  ok, is_w, rdy;
    logic [63:0] exp_d;
    is_w = (msg == WR) || (msg == UCWR);
    n    = nbeats(int'(size));
    nrev = is_w ? 1 : n;
    for (int b = 0; b < (is_w ? n : 1); b++) begin
      mem_if.mem_fwd_v = 1'b1;
      if (b == 0) begin
        mem_if.mem_fwd_msg_type = msg;
        mem_if.mem_fwd_size     = size;
        mem_if.mem_fwd_addr     = addr;
        mem_if.mem_fwd_payload  = payload;
      end else begin
        mem_if.mem_fwd_msg_type = 4'($urandom);
        mem_if.mem_fwd_size     = 3'($urandom);
        mem_if.mem_fwd_addr     = {8'($urandom), 32'($urandom)};
        mem_if.mem_fwd_payload  = 16'($urandom);
      end
      mem_if.mem_fwd_data = wbuf[b];
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
        if (mem_if.mem_fwd_ready_and) ok = 1'b1;
        @(posedge clk); #1;
      end
      check("fwd_accept", 64'(ok), 64'd1);
      if (is_w) model_write(addr, int'(size), b, wbuf[b]);
    end
    // keep offering a junk read: nothing may be accepted until the response completes
    mem_if.mem_fwd_v        = 1'b1;
    mem_if.mem_fwd_msg_type = RD;
    mem_if.mem_fwd_size     = 3'd3;
    mem_if.mem_fwd_addr     = {8'h80, 32'($urandom)};
    cyc = 0;
    while (!mem_if.mem_rev_v && cyc < 100) begin
      check("fwd_closed_wait", 64'(mem_if.mem_fwd_ready_and), 64'd0);
      @(posedge clk); #1;
      cyc++;
    end
    check("rev_latency", 64'(cyc), 64'(LAT));
    xfers = 0; cyc = 0; pat = 0;
    while (xfers < nrev && cyc < 300) begin
      rdy = (bp_mode == 0) ? 1'b1 : (bp_mode == 1) ? (pat % 3 == 0) : 1'($urandom);
      pat++;
      mem_if.mem_rev_ready_and = rdy;
      exp_d = is_w ? 64'd0 : exp_read(addr, int'(size), xfers);
      check("rev_v", 64'(mem_if.mem_rev_v), 64'd1);
      check("rev_data", mem_if.mem_rev_data, exp_d);
      check("rev_addr", 64'(mem_if.mem_rev_addr), 64'(is_w ? addr : exp_addr(addr, int'(size), xfers)));
      check("rev_msg", 64'(mem_if.mem_rev_msg_type), 64'(msg));
      check("rev_size", 64'(mem_if.mem_rev_size), 64'(size));
      check("rev_payload", 64'(mem_if.mem_rev_payload), 64'(payload));
      check("fwd_closed_rev", 64'(mem_if.mem_fwd_ready_and), 64'd0);
      if (rdy) begin
        beat_log[xfers] = mem_if.mem_rev_data;
        xfers++;
      end
      @(posedge clk); #1;
      cyc++;
      if (abort_after > 0 && xfers == abort_after) begin
        #2 reset_n = 1'b0;
        #1;
        check("abort_rev_v", 64'(mem_if.mem_rev_v), 64'd0);
        check("abort_rev_data", mem_if.mem_rev_data, 64'd0);
        check("abort_fwd_ready", 64'(mem_if.mem_fwd_ready_and), 64'd0);
        mem_if.mem_fwd_v = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
          @(posedge clk); #1;
          check("no_partial_rev", 64'(mem_if.mem_rev_v), 64'd0);
        end
        return;
      end
    end
    mem_if.mem_fwd_v = 1'b0;
    check("rev_xfers", 64'(xfers), 64'(nrev));
    check("rev_done_v", 64'(mem_if.mem_rev_v), 64'd0);
    check("fwd_reopen", 64'(mem_if.mem_fwd_ready_and), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] base;
    int          sz, off;
    mem_if.mem_fwd_v         = 1'b1;
    mem_if.mem_fwd_msg_type  = RD;
    mem_if.mem_fwd_size      = 3'd3;
    mem_if.mem_fwd_addr      = 40'h80000000;
    mem_if.mem_fwd_payload   = '0;
    mem_if.mem_fwd_data      = '0;
    mem_if.mem_rev_ready_and = 1'b1;

    // T1 reset held with fwd_v asserted
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("rst_ready", 64'(mem_if.mem_fwd_ready_and), 64'd0);
      check("rst_rev_v", 64'(mem_if.mem_rev_v), 64'd0);
    end
    check("rst_rev_data", mem_if.mem_rev_data, 64'd0);
    check("rst_rev_addr", 64'(mem_if.mem_rev_addr), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_release", 64'(mem_if.mem_fwd_ready_and), 64'd1);
    mem_if.mem_fwd_v = 1'b0;
    @(posedge clk); #1;
    check("no_handshake_in_reset", 64'(mem_if.mem_fwd_ready_and), 64'd1);
    check("no_rev_after_reset", 64'(mem_if.mem_rev_v), 64'd0);

    // T2 uc write then uc read
    wbuf[0] = 64'hDEADBEEF_01234567;
    do_txn(UCWR, 3'd3, 40'h80001000, 16'h1111, 0, 0);
    do_txn(UCRD, 3'd3, 40'h80001000, 16'h2222, 0, 0);
    check("t2_read_data", beat_log[0], 64'hDEADBEEF_01234567);

    // T3 block write, then critical-word-first block read
    for (int k = 0; k < 8; k++) wbuf[k] = 64'(16 + k);
    do_txn(WR, 3'd6, 40'h80002000, 16'h3333, 0, 0);
    do_txn(RD, 3'd6, 40'h80002028, 16'h4444, 0, 0);
    check("t3_first_beat", beat_log[0], 64'h15);
    check("t3_wrap_beat", beat_log[3], 64'h10);
    check("t3_last_beat", beat_log[7], 64'h14);

    // T4 same read under 1,0,0 backpressure
    do_txn(RD, 3'd6, 40'h80002028, 16'h5555, 1, 0);
    check("t4_first_beat", beat_log[0], 64'h15);
    check("t4_last_beat", beat_log[7], 64'h14);

    // T5 2-byte write onto a zeroed word, then full and sub-beat reads
    wbuf[0] = 64'h0;
    do_txn(UCWR, 3'd3, 40'h80003000, 16'h6666, 0, 0);
    wbuf[0] = {4{16'hABCD}};
    do_txn(WR, 3'd1, 40'h80003006, 16'h7777, 0, 0);
    do_txn(RD, 3'd3, 40'h80003000, 16'h8888, 0, 0);
    check("t5_word", beat_log[0], 64'hABCD0000_00000000);
    do_txn(UCRD, 3'd1, 40'h80003006, 16'h9999, 2, 0);
    check("t5_replicated", beat_log[0], {4{16'hABCD}});

    // T6 reset during block read, then a clean read
    do_txn(RD, 3'd6, 40'h80002000, 16'hAAAA, 0, 3);
    do_txn(RD, 3'd6, 40'h80002000, 16'hBBBB, 0, 0);
    check("t6_recover_first", beat_log[0], 64'h10);

    // random traffic over a 512-byte preloaded window
    base = 40'h80004800;
    for (int r = 0; r < 8; r++) begin
      for (int b = 0; b < 8; b++) wbuf[b] = {$urandom, $urandom};
      do_txn(WR, 3'd6, base + 40'(64 * r), 16'($urandom), 2, 0);
    end
    for (int t = 0; t < 40; t++) begin
      sz  = int'($urandom_range(0, 7));
      off = int'($urandom_range(0, 511));
      off = (sz < 3) ? (off & ~((1 << sz) - 1)) : (off & ~7);
      for (int b = 0; b < 16; b++) wbuf[b] = {$urandom, $urandom};
      do_txn(4'($urandom_range(0, 3)), 3'(sz), base + 40'(off), 16'($urandom),
             int'($urandom_range(0, 2)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
